// File: rtl/tag_arbiter_rr.sv
// tag_arbiter_rr: picks one of N ready requesters and offers its index as a tag
// on a registered rdy/ack handshake. Supports one grant per cycle (back-to-back).
//
// Parameters:
//   N         number of requesters (1..256)
//   TAG_SZ    tag width, >= clog2(N) (1 when N=1); the index is zero-extended
//   PRIO_MODE 0 = round-robin from the rotating pointer, 1 = lowest index wins
//
// Ports:
//   clk      clock, all state on the rising edge
//   rst      synchronous active-high reset
//   rdy_in   level request per requester
//   mask     per-requester enable (only when TAG_ARB_MASK_EN is defined)
//   ack_out  one-hot acceptance pulse to the granted requester (combinational)
//   tag      index of the offered requester (registered)
//   rdy      tag valid (registered)
//   ack      downstream accepts the current tag; ignored while rdy=0
//
// Optional feature macro: TAG_ARB_MASK_EN adds the mask input.
module tag_arbiter_rr #(
  parameter int unsigned N         = 8,
  parameter int unsigned TAG_SZ    = 5,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      rdy_in,
`ifdef TAG_ARB_MASK_EN
  input  logic [N-1:0]      mask,
`endif
  output logic [N-1:0]      ack_out,
  output logic [TAG_SZ-1:0] tag,
  output logic              rdy,
  input  logic              ack
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] ptr_inc;
  logic [IW-1:0] scan_start;
  logic [IW-1:0] ack_start;
  logic [N-1:0]  cand;
  logic [N-1:0]  tag_oh;
  logic [N-1:0]  cand_rest;
  logic [IW:0]   pick_idle;
  logic [IW:0]   pick_ack;

  // Returns {found, index} of the first set bit of c scanning start, start+1, ..., wrapping at N.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] c, input logic [IW-1:0] start);
    logic [IW:0] res;
    int unsigned k;
    res = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = 32'(start) + i;
      if (k >= N) k = k - N;
      if (!res[IW] && |(c & (N'(1) << k))) res = {1'b1, IW'(k)};
    end
    return res;
  endfunction

`ifdef TAG_ARB_MASK_EN
  assign cand = rdy_in & mask;
`else
  assign cand = rdy_in;
`endif

  assign tag_oh    = N'(1) << idx_q;
  // The just-acked requester sits out the reselect in the ack cycle.
  assign cand_rest = cand & ~tag_oh;
  // Explicit wrap so non-power-of-2 N never produces an index >= N.
  assign ptr_inc   = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;

  // Fixed-priority mode scans from 0 and keeps the pointer parked at 0.
  assign scan_start = (PRIO_MODE != 0) ? '0 : ptr_q;
  assign ack_start  = (PRIO_MODE != 0) ? '0 : ptr_inc;

  assign pick_idle = rr_pick(cand, scan_start);
  assign pick_ack  = rr_pick(cand_rest, ack_start);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_idle[IW]) begin
          state_d = StOffer;
          idx_d   = pick_idle[IW-1:0];
        end
      end
      StOffer: begin
        if (ack) begin
          ptr_d = ack_start;
          if (pick_ack[IW]) begin
            idx_d = pick_ack[IW-1:0];
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign tag     = TAG_SZ'(idx_q);
  assign rdy     = (state_q == StOffer);
  assign ack_out = {N{rdy & ack & ~rst}} & tag_oh;

endmodule
